// File: rtl/operand_fetch_stage_pkg.sv
// Shared widths, zero-register constant and state encoding for the operand fetch stage.
package operand_fetch_stage_pkg;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 4;
    localparam int ZERO_REG   = 0;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ofs_state_e;

endpackage

// File: rtl/operand_fetch_stage_register_bank.sv
// Register bank: two async read ports, one sync write port, entry 0 reads as zero.
module register_bank
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int NUM_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    // Entry 0 is reset with the rest and never written, so it stays zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
        end else if (we && (waddr != ADDR_W'(ZERO_REG))) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata_a = mem_q[raddr_a];
    assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/operand_fetch_stage.sv
// Operand fetch: register bank read, write-back bypass select, one-entry output register.
// Optional OPERAND_HOLD_REFRESH_EN: held operands track write-backs to their source during a stall.
module operand_fetch_stage
    import operand_fetch_stage_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] B_R_Out_1,
    input  logic [ADDR_W-1:0] B_R_Out_2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] B_R_Address_to_write,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              by_pass_A,
    input  logic              by_pass_B,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [ADDR_W-1:0] out_rs_a,
    output logic [ADDR_W-1:0] out_rs_b
);

    ofs_state_e        state_q;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [ADDR_W-1:0] rs_a_q, rs_b_q;
    logic [DATA_W-1:0] bank_a, bank_b, sel_a, sel_b;
    logic              fwd_a, fwd_b, accept;

    register_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
        .clock   (clock),
        .reset   (reset),
        .raddr_a (B_R_Out_1),
        .raddr_b (B_R_Out_2),
        .rdata_a (bank_a),
        .rdata_b (bank_b),
        .we      (wb_en),
        .waddr   (B_R_Address_to_write),
        .wdata   (wb_data)
    );

    // The forwarding unit flags on address match only, so qualify with the live write.
    assign fwd_a  = by_pass_A & wb_en & (B_R_Out_1 != ADDR_W'(ZERO_REG));
    assign fwd_b  = by_pass_B & wb_en & (B_R_Out_2 != ADDR_W'(ZERO_REG));
    assign sel_a  = fwd_a ? wb_data : bank_a;
    assign sel_b  = fwd_b ? wb_data : bank_b;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid | out_ready;
    assign accept    = in_valid & in_ready;

    always_comb begin
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        if (accept) begin
            op_a_d = sel_a;
            op_b_d = sel_b;
        end
`ifdef OPERAND_HOLD_REFRESH_EN
        else if (out_valid && !out_ready && wb_en) begin
            if (B_R_Address_to_write == rs_a_q && rs_a_q != ADDR_W'(ZERO_REG)) op_a_d = wb_data;
            if (B_R_Address_to_write == rs_b_q && rs_b_q != ADDR_W'(ZERO_REG)) op_b_d = wb_data;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            op_a_q  <= '0;
            op_b_q  <= '0;
            rs_a_q  <= '0;
            rs_b_q  <= '0;
        end else begin
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            if (accept) begin
                rs_a_q <= B_R_Out_1;
                rs_b_q <= B_R_Out_2;
            end
            case (state_q)
                ST_EMPTY: if (accept) state_q <= ST_FULL;
                ST_FULL:  if (out_ready && !accept) state_q <= ST_EMPTY;
                default:  state_q <= ST_EMPTY;
            endcase
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign out_rs_a = rs_a_q;
    assign out_rs_b = rs_b_q;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage; expectations follow OPERAND_HOLD_REFRESH_EN when defined.
module tb_operand_fetch_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [3:0]  B_R_Out_1 = '0, B_R_Out_2 = '0, B_R_Address_to_write = '0;
    logic        wb_en = 1'b0, by_pass_A = 1'b0, by_pass_B = 1'b0;
    logic [15:0] wb_data = '0;
    logic        out_valid, out_ready = 1'b1;
    logic [15:0] op_a, op_b;
    logic [3:0]  out_rs_a, out_rs_b;

    operand_fetch_stage dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .B_R_Out_1(B_R_Out_1), .B_R_Out_2(B_R_Out_2),
        .wb_en(wb_en), .B_R_Address_to_write(B_R_Address_to_write), .wb_data(wb_data),
        .by_pass_A(by_pass_A), .by_pass_B(by_pass_B),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_a(op_a), .op_b(op_b), .out_rs_a(out_rs_a), .out_rs_b(out_rs_b)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  ra;
        logic [3:0]  rb;
    } exp_t;

    exp_t        q[$];
    logic [15:0] bank [16];
    logic        mfull = 1'b0;
    int          checks = 0, failures = 0, pushes = 0, pops = 0;

    // Inputs are already driven in the low phase; check, predict the edge, advance one cycle.
    task automatic cycle();
        exp_t e;
        logic acc, fa, fb;
        #1;
        checks++;
        if (out_valid !== mfull) begin
            failures++; $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, mfull, $time);
        end
        checks++;
        if (in_ready !== (!mfull || out_ready)) begin
            failures++; $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, (!mfull || out_ready), $time);
        end
        if (mfull) begin
            checks++;
            if (q.size() == 0) begin
                failures++; $display("FAIL scoreboard_empty while out_valid t=%0t", $time);
            end else begin
                if ({op_a, op_b, out_rs_a, out_rs_b} !== {q[0].a, q[0].b, q[0].ra, q[0].rb}) begin
                    failures++;
                    $display("FAIL pair got=%h/%h rs=%0d/%0d exp=%h/%h rs=%0d/%0d t=%0t",
                             op_a, op_b, out_rs_a, out_rs_b, q[0].a, q[0].b, q[0].ra, q[0].rb, $time);
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    pops++;
                end
            end
        end
        acc = in_valid && (!mfull || out_ready);
        if (acc) begin
            fa   = by_pass_A && wb_en && (B_R_Out_1 != 4'd0);
            fb   = by_pass_B && wb_en && (B_R_Out_2 != 4'd0);
            e.a  = fa ? wb_data : bank[B_R_Out_1];
            e.b  = fb ? wb_data : bank[B_R_Out_2];
            e.ra = B_R_Out_1;
            e.rb = B_R_Out_2;
            q.push_back(e);
            pushes++;
        end
`ifdef OPERAND_HOLD_REFRESH_EN
        else if (mfull && !out_ready && wb_en && q.size() > 0) begin
            if (q[0].ra != 4'd0 && q[0].ra == B_R_Address_to_write) q[0].a = wb_data;
            if (q[0].rb != 4'd0 && q[0].rb == B_R_Address_to_write) q[0].b = wb_data;
        end
`endif
        mfull = acc ? 1'b1 : (out_ready ? 1'b0 : mfull);
        if (wb_en && B_R_Address_to_write != 4'd0) bank[B_R_Address_to_write] = wb_data;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [3:0] ra, input logic [3:0] rb,
                         input logic pa, input logic pb, input logic we,
                         input logic [3:0] wa, input logic [15:0] wd, input logic ordy);
        in_valid = v; B_R_Out_1 = ra; B_R_Out_2 = rb;
        by_pass_A = pa; by_pass_B = pb;
        wb_en = we; B_R_Address_to_write = wa; wb_data = wd;
        out_ready = ordy;
        cycle();
    endtask

    task automatic wr(input logic [3:0] wa, input logic [15:0] wd);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, wa, wd, 1'b1);
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) bank[i] = 16'h0;
        #12;
        checks++;
        if ({in_ready, out_valid, op_a, op_b, out_rs_a, out_rs_b} !== {1'b1, 1'b0, 40'h0}) begin
            failures++;
            $display("FAIL reset_values rdy=%b vld=%b a=%h b=%h rs=%0d/%0d", in_ready, out_valid,
                     op_a, op_b, out_rs_a, out_rs_b);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic preload();
        for (int i = 1; i < 16; i++) wr(4'(i), 16'(i * 16'h0101));
    endtask

    task automatic test_forward();
        wr(4'd5, 16'h0011);
        drive(1'b1, 4'd5, 4'd1, 1'b1, 1'b0, 1'b1, 4'd5, 16'h00AA, 1'b1);
        checks++;
        if (op_a !== 16'h00AA) begin failures++; $display("FAIL fwd_a got=%h exp=00aa", op_a); end
        wr(4'd5, 16'h0011);
        drive(1'b1, 4'd5, 4'd1, 1'b0, 1'b0, 1'b1, 4'd5, 16'h00AA, 1'b1);
        checks++;
        if (op_a !== 16'h0011) begin failures++; $display("FAIL bank_read_a got=%h exp=0011", op_a); end
        idle();
    endtask

    task automatic test_gated_bypass();
        wr(4'd7, 16'h0042);
        drive(1'b1, 4'd1, 4'd7, 1'b0, 1'b1, 1'b0, 4'd7, 16'h9999, 1'b1);
        checks++;
        if (op_b !== 16'h0042) begin failures++; $display("FAIL gated_b got=%h exp=0042", op_b); end
        drive(1'b1, 4'd0, 4'd1, 1'b1, 1'b0, 1'b1, 4'd9, 16'hFFFF, 1'b1);
        checks++;
        if (op_a !== 16'h0000) begin failures++; $display("FAIL zero_reg_a got=%h exp=0000", op_a); end
        idle();
    endtask

    task automatic test_backpressure();
        logic [15:0] ha, hb;
        drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        ha = op_a; hb = op_b;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(i + 3), 4'(i + 4), 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
            checks++;
            if ({op_a, op_b} !== {ha, hb}) begin
                failures++; $display("FAIL stall_hold got=%h/%h exp=%h/%h", op_a, op_b, ha, hb);
            end
        end
        for (int i = 0; i < 4; i++) drive(1'b1, 4'(i + 8), 4'(12 - i), 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        idle();
        checks++;
        if (q.size() != 0 || pushes != pops) begin
            failures++; $display("FAIL bp_count q=%0d pushes=%0d pops=%0d exp q=0 equal", q.size(), pushes, pops);
        end
    endtask

    task automatic test_hold_refresh();
        logic [15:0] exp_a;
        wr(4'd2, 16'h0101);
        drive(1'b1, 4'd2, 4'd4, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 4'd2, 16'hBEEF, 1'b0);
`ifdef OPERAND_HOLD_REFRESH_EN
        exp_a = 16'hBEEF;
`else
        exp_a = 16'h0101;
`endif
        checks++;
        if (op_a !== exp_a) begin failures++; $display("FAIL hold_refresh_a got=%h exp=%h", op_a, exp_a); end
        idle();
    endtask

    task automatic test_reset_midstream();
        wr(4'd3, 16'h1234);
        drive(1'b1, 4'd3, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0);
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, op_a} !== {1'b0, 16'h0}) begin
            failures++; $display("FAIL mid_reset vld=%b a=%h exp vld=0 a=0000", out_valid, op_a);
        end
        q.delete();
        mfull = 1'b0;
        for (int i = 0; i < 16; i++) bank[i] = 16'h0;
        @(negedge clock);
        reset = 1'b1;
        drive(1'b1, 4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1);
        checks++;
        if (op_a !== 16'h0) begin failures++; $display("FAIL r3_after_reset got=%h exp=0000", op_a); end
        idle();
    endtask

    task automatic test_back_to_back();
        preload();
        for (int i = 0; i < 60; i++)
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0));
        idle();
        checks++;
        if (q.size() != 0) begin failures++; $display("FAIL b2b_leftover q=%0d exp=0", q.size()); end
    endtask

    initial begin
        test_reset();
        preload();
        test_forward();
        test_gated_bypass();
        test_backpressure();
        test_hold_refresh();
        test_reset_midstream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
# operand_fetch_stage

Register-bank and operand-select stage of the pipeline. It holds the 16-entry register bank, reads two source registers, and consumes the `by_pass_A`/`by_pass_B` flags from the forwarding unit to choose between bank contents and write-back data. It registers the selected operands into the execute stage behind a valid/ready handshake.

## Interface
- `DATA_W`, default 16, operand and register width.
- `ADDR_W`, default 4, register address width; the bank has 2^ADDR_W entries.
- `clock`  in  1  single clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (the only reset in the block).
- `in_valid`  in  1  decode presents a source-address pair.
- `in_ready`  out  1  stage accepts the pair this cycle.
- `B_R_Out_1`  in  ADDR_W  source register A address.
- `B_R_Out_2`  in  ADDR_W  source register B address.
- `wb_en`  in  1  write-back strobe.
- `B_R_Address_to_write`  in  ADDR_W  write-back destination address.
- `wb_data`  in  DATA_W  write-back value.
- `by_pass_A`  in  1  forwarding request for operand A.
- `by_pass_B`  in  1  forwarding request for operand B.
- `out_valid`  out  1  the operand register holds a valid pair.
- `out_ready`  in  1  execute consumes the pair.
- `op_a`  out  DATA_W  registered operand A.
- `op_b`  out  DATA_W  registered operand B.
- `out_rs_a`  out  ADDR_W  address captured with `op_a`.
- `out_rs_b`  out  ADDR_W  address captured with `op_b`.

## Operation
- **Register bank:** 2^ADDR_W × DATA_W; all entries reset to 0.
  - Entry 0 is hardwired to 0, and writes to it are ignored.
  - Writes take effect at the clock edge when `wb_en`=1.
- **Effective bypass:** `fwd_a = by_pass_A & wb_en & (B_R_Out_1 != 0)`; `fwd_b` is formed the same way from `by_pass_B` and `B_R_Out_2`.
  - `wb_en` gating is mandatory because the forwarding unit asserts bypass on an address match alone.
- **Operand select (combinational):** `sel_a = fwd_a ? wb_data : bank[B_R_Out_1]`; `sel_b` is selected the same way.
- **Handshake:**
  - `in_ready = !out_valid | out_ready`.
  - Accept when `in_valid & in_ready`. On accept, load `op_a`/`op_b` from `sel_a`/`sel_b`, load `out_rs_a`/`out_rs_b` from the input addresses, and set `out_valid`=1.
  - When `out_valid & out_ready` with no new accept, clear `out_valid`.
  - Accept and drain in the same cycle replace the held pair with no bubble.
- **Two-state control:** EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - EMPTY→FULL on accept.
  - FULL→EMPTY on drain without accept.
  - FULL→FULL on drain with accept, or on stall.
- **Stall:** while FULL and `!out_ready`, `op_a`/`op_b` are held; the only exception is the refresh described under Configuration.
- **Reset mid-operation:** asserting `reset` immediately forces EMPTY, clears the bank and all outputs, and discards the held pair.

## Timing
- **Reset values:** `in_ready`=1, `out_valid`=0, `op_a`=`op_b`=0, `out_rs_a`=`out_rs_b`=0.
- **Latency:** one cycle from accept to `out_valid`, with operands valid on the same edge.
- **Same-cycle write and read:** a read of the address being written returns `wb_data` only through `fwd_*`. Without bypass it returns the old bank value; the new value is visible from the next cycle.
- **Throughput:** one pair per cycle while `out_ready`=1.
- **Bypass flags:** sampled only in the accept cycle.

## Configuration
- **`OPERAND_HOLD_REFRESH_EN` defined:** while FULL and stalled, if `wb_en` and `B_R_Address_to_write == out_rs_a` (nonzero), `op_a` loads `wb_data` at that edge. `op_b` refreshes the same way against `out_rs_b`. Both refresh when both match.
- **`OPERAND_HOLD_REFRESH_EN` undefined:** held operands never change during a stall. Upstream must not issue a write-back to a held source register.

## Structure
- **Shared package:** `DATA_W`/`ADDR_W` defaults, the `ZERO_REG` constant (0), and the EMPTY/FULL state encoding.
- **Sub-module `register_bank`:** the bank, with two asynchronous read ports, one synchronous write port, the entry-0 hardwire and asynchronous clear. The top level holds the bypass muxes, the handshake and the refresh logic.

## Test plan
- **Reset mid-stream:**
  - Stimulus: write r3=0x1234, hold FULL, then pulse `reset` low.
  - Required: `out_valid`=0, `op_a`=0, and a later read of r3 returns 0.
- **Forward vs bank read:**
  - Stimulus: bank r5=0x0011; in the same cycle `wb_en`=1 to r5 with 0x00AA, `B_R_Out_1`=5, `by_pass_A`=1.
  - Required: `op_a`=0x00AA. Repeat with `by_pass_A`=0: `op_a`=0x0011.
- **Gated bypass:**
  - Stimulus: `by_pass_B`=1, `wb_en`=0, r7=0x0042.
  - Required: `op_b`=0x0042.
  - Stimulus: address 0 with `by_pass_A`=1, `wb_en`=1, `wb_data`=0xFFFF.
  - Required: `op_a`=0.
- **Back-pressure:**
  - Stimulus: `out_ready`=0 for 3 cycles with `in_valid`=1.
  - Required: `in_ready`=0 and the operands stable; on release exactly one new pair is accepted per cycle, with no loss or duplication.
- **Hold refresh (macro defined):**
  - Stimulus: held pair with `out_rs_a`=2; write r2=0xBEEF during the stall.
  - Required: `op_a`=0xBEEF on the next cycle. With the macro undefined, `op_a` is unchanged.
